// File: rtl/hazard_control.sv
// -----------------------------------------------------------------------------
// hazard_control
//
// Pipeline hazard and stall controller. Generates the `nop` hold for the PC
// register and the hold / flush / bubble controls for the IF/ID, ID/EX and
// EX/MEM pipeline registers.
//
// Handled conditions:
//   - load-use data hazard (load in EX feeding a source read in ID)
//   - taken branch/jump resolved in EX
//   - multi-cycle data-memory access (MEM stage freeze)
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   : stall_cycles / flush_count are live 16-bit wrapping counters
//   undefined : both ports are tied to zero and no counter flops exist
//
// Ports:
//   clk            in   pipeline clock, state updates on rising edge
//   reset          in   asynchronous active-low reset
//   idex_mem_read  in   instruction in EX is a load
//   idex_rd        in   destination register of instruction in EX
//   ifid_rs1/rs2   in   source registers of instruction in ID
//   ifid_rs*_used  in   qualifies each source as actually read
//   branch_taken   in   EX resolved a taken branch/jump this cycle
//   mem_busy       in   data memory not ready, MEM stage must freeze
//   pc_nop         out  hold PC
//   ifid_hold      out  IF/ID keeps contents
//   ifid_flush     out  IF/ID loads a NOP
//   idex_hold      out  ID/EX keeps contents
//   idex_bubble    out  ID/EX loads a bubble
//   exmem_hold     out  EX/MEM keeps contents
//   stall_active   out  FSM not in RUN
//   stall_cycles   out  cycles with pc_nop=1 (perf counter)
//   flush_count    out  accepted taken branches (perf counter)
//   state_dbg      out  current FSM state (RUN=0, STALL=1, FLUSH=2, WAIT=3)
//
// Handshake note: there is no valid/ready handshake here. Every output is a
// combinational (Mealy) function of the registered state and the current
// inputs, taking effect in the same cycle; consumers sample them on the next
// rising edge of clk.
// -----------------------------------------------------------------------------
module hazard_control #(
   parameter int REG_ADDR_W        = 4,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  idex_mem_read,
   input  logic [REG_ADDR_W-1:0] idex_rd,
   input  logic [REG_ADDR_W-1:0] ifid_rs1,
   input  logic [REG_ADDR_W-1:0] ifid_rs2,
   input  logic                  ifid_rs1_used,
   input  logic                  ifid_rs2_used,
   input  logic                  branch_taken,
   input  logic                  mem_busy,
   output logic                  pc_nop,
   output logic                  ifid_hold,
   output logic                  ifid_flush,
   output logic                  idex_hold,
   output logic                  idex_bubble,
   output logic                  exmem_hold,
   output logic                  stall_active,
   output logic [15:0]           stall_cycles,
   output logic [15:0]           flush_count,
   output logic [1:0]            state_dbg
);

   localparam logic [1:0] RUN   = 2'd0;
   localparam logic [1:0] STALL = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [1:0] WAIT  = 2'd3;

   // Reload values for the down-counter. The first stall/flush cycle happens
   // while still in RUN, so the extra cycles spent in STALL/FLUSH are N-1,
   // which a counter terminating at zero covers with a reload of N-2.
   localparam int STALL_RELOAD_I = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0;
   localparam int FLUSH_RELOAD_I = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
   localparam logic [2:0] STALL_RELOAD = 3'(STALL_RELOAD_I);
   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_RELOAD_I);

   logic [1:0] state;
   logic [1:0] next_state;
   logic [2:0] cnt;
   logic [2:0] next_cnt;

   logic luh;
   logic run_like;
   logic sel_wait;
   logic sel_branch;
   logic sel_luh;
   logic sel_stall;
   logic sel_flush;

   logic pc_nop_int;
   logic ifid_hold_int;
   logic ifid_flush_int;
   logic idex_hold_int;
   logic idex_bubble_int;
   logic exmem_hold_int;

   // Register 0 is hard-wired zero, so a load targeting it never hazards.
   assign luh = idex_mem_read && (idex_rd != '0) &&
                ((ifid_rs1_used && (ifid_rs1 == idex_rd)) ||
                 (ifid_rs2_used && (ifid_rs2 == idex_rd)));

   // The exit cycle of WAIT behaves exactly like RUN: the frozen branch or
   // load-use condition reappears now that EX is moving again.
   assign run_like = (state == RUN) || ((state == WAIT) && !mem_busy);

   // One-hot selection of the action for this cycle. mem_busy wins in every
   // state; a taken branch beats a pending stall or flush; a load-use hazard
   // is only started from a RUN-like cycle (in STALL it is already being
   // served, in FLUSH the ID instruction is being discarded).
   assign sel_wait   = mem_busy;
   assign sel_branch = !mem_busy && branch_taken;
   assign sel_luh    = !mem_busy && !branch_taken && luh && run_like;
   assign sel_stall  = !mem_busy && !branch_taken && (state == STALL);
   assign sel_flush  = !mem_busy && !branch_taken && (state == FLUSH);

   assign pc_nop_int      = sel_wait | sel_luh | sel_stall;
   assign ifid_hold_int   = sel_wait | sel_luh | sel_stall;
   assign ifid_flush_int  = sel_branch | sel_flush;
   assign idex_hold_int   = sel_wait;
   assign idex_bubble_int = sel_branch | sel_luh | sel_stall | sel_flush;
   assign exmem_hold_int  = sel_wait;

   // All hazard outputs are forced low while reset is asserted.
   assign pc_nop       = reset & pc_nop_int;
   assign ifid_hold    = reset & ifid_hold_int;
   assign ifid_flush   = reset & ifid_flush_int;
   assign idex_hold    = reset & idex_hold_int;
   assign idex_bubble  = reset & idex_bubble_int;
   assign exmem_hold   = reset & exmem_hold_int;
   assign stall_active = (state != RUN);
   assign state_dbg    = state;

   always_comb begin
      next_state = RUN;
      next_cnt   = cnt;
      if (sel_wait) begin
         next_state = WAIT;
      end else if (sel_branch) begin
         if (FLUSH_CYCLES > 1) begin
            next_state = FLUSH;
            next_cnt   = FLUSH_RELOAD;
         end else begin
            next_state = RUN;
         end
      end else if (sel_luh) begin
         if (LOAD_STALL_CYCLES > 1) begin
            next_state = STALL;
            next_cnt   = STALL_RELOAD;
         end else begin
            next_state = RUN;
         end
      end else if (sel_stall || sel_flush) begin
         if (cnt == 3'd0) begin
            next_state = RUN;
         end else begin
            next_state = state;
            next_cnt   = cnt - 3'd1;
         end
      end else begin
         next_state = RUN;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
         cnt   <= 3'd0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cycles_q;
   logic [15:0] flush_count_q;

   // Both counters wrap naturally at 16 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles_q <= 16'd0;
         flush_count_q  <= 16'd0;
      end else begin
         if (pc_nop_int) begin
            stall_cycles_q <= stall_cycles_q + 16'd1;
         end
         if (sel_branch) begin
            flush_count_q <= flush_count_q + 16'd1;
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   assign stall_cycles = 16'd0;
   assign flush_count  = 16'd0;
`endif

   // Contradictory register controls must never be requested together.
   a_ifid_excl : assert property (@(posedge clk) disable iff (!reset)
      !(ifid_flush && ifid_hold));
   a_idex_excl : assert property (@(posedge clk) disable iff (!reset)
      !(idex_hold && idex_bubble));

endmodule
